// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - round-robin two-requester arbiter and setup/strobe/done I/O bus sequencer
module io_arbiter #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic       a_err,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic       b_err,
  output logic [7:0] b_rdata,
  output logic [7:0] io_addr,
  output logic       io_RE,
  output logic       io_WE,
  output logic [7:0] io_Din,
  input  logic [7:0] io_Dout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       owner, owner_nx;        // 0 = A, 1 = B
  logic       last_gnt, last_gnt_nx;  // 0 = A, 1 = B
  logic       we_q, we_nx;

  logic [7:0] io_addr_nx, io_din_nx, a_rdata_nx, b_rdata_nx;
  logic       io_re_nx, io_we_nx, a_ack_nx, b_ack_nx, a_err_nx, b_err_nx, busy_nx;

  logic       gnt_b, gnt_we;
  logic [7:0] gnt_addr, gnt_wdata;

  always_comb begin
    gnt_b     = (a_req && b_req) ? ~last_gnt : b_req;
    gnt_we    = gnt_b ? b_we : a_we;
    gnt_addr  = gnt_b ? b_addr : a_addr;
    gnt_wdata = gnt_b ? b_wdata : a_wdata;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    owner_nx    = owner;
    last_gnt_nx = last_gnt;
    we_nx       = we_q;
    io_addr_nx  = io_addr;
    io_din_nx   = io_Din;
    io_re_nx    = 1'b0;
    io_we_nx    = 1'b0;
    a_ack_nx    = 1'b0;
    b_ack_nx    = 1'b0;
    a_err_nx    = 1'b0;
    b_err_nx    = 1'b0;
    a_rdata_nx  = a_rdata;
    b_rdata_nx  = b_rdata;

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          owner_nx    = gnt_b;
          last_gnt_nx = gnt_b;
          we_nx       = gnt_we;
          if (gnt_addr > 8'h07) begin
            // Rejected addresses skip the bus entirely and complete next cycle.
            state_nx = DONE;
            a_ack_nx = ~gnt_b;
            b_ack_nx = gnt_b;
            a_err_nx = ~gnt_b;
            b_err_nx = gnt_b;
          end else begin
            state_nx   = SETUP;
            io_addr_nx = gnt_addr;
            io_din_nx  = gnt_wdata;
          end
        end
      end

      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = 4'd0;
        io_re_nx = ~we_q;
        io_we_nx = we_q;
      end

      STROBE: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == LAST_CNT) begin
          state_nx = DONE;
          a_ack_nx = ~owner;
          b_ack_nx = owner;
          if (!we_q) begin
            if (owner) b_rdata_nx = io_Dout;
            else       a_rdata_nx = io_Dout;
          end
        end else begin
          io_re_nx = ~we_q;
          io_we_nx = we_q;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      io_addr  <= 8'h00;
      io_Din   <= 8'h00;
      io_RE    <= 1'b0;
      io_WE    <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata  <= 8'h00;
      b_rdata  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      owner    <= owner_nx;
      last_gnt <= last_gnt_nx;
      we_q     <= we_nx;
      io_addr  <= io_addr_nx;
      io_Din   <= io_din_nx;
      io_RE    <= io_re_nx;
      io_WE    <= io_we_nx;
      a_ack    <= a_ack_nx;
      b_ack    <= b_ack_nx;
      a_err    <= a_err_nx;
      b_err    <= b_err_nx;
      a_rdata  <= a_rdata_nx;
      b_rdata  <= b_rdata_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - scoreboard bench for io_arbiter at strobe widths 2, 1 and 15
`timescale 1ns/1ps
module tb_io_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, go_rst, go2, fin;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dtab [64];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct { bit b; bit err; logic [7:0] rd; int at; } exp_t;
  typedef struct { bit we; logic [7:0] addr; logic [7:0] din; int start; } str_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int SC = (g == 0) ? 2 : (g == 1) ? 1 : 15;

    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, a_err, b_ack, b_err;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] io_addr, io_Din, io_Dout;
    logic       io_RE, io_WE, busy;
    logic       done1, done2;

    // Dout changes every cycle so the capture edge is pinned down exactly.
    assign io_Dout = dtab[cyc % 64];

    io_arbiter #(.STROBE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .io_addr(io_addr), .io_RE(io_RE), .io_WE(io_WE), .io_Din(io_Din),
      .io_Dout(io_Dout), .busy(busy)
    );

    // Reference model: schedules each grant's ack and strobe window by edge number.
    exp_t       eq[$];
    str_t       sq[$];
    int         next_idle = 0;
    int         busy_last = -1;
    bit         last_b = 1'b1;
    bit         rst_seen = 1'b0;
    logic [7:0] mrd [2];

    always @(posedge clk) begin : model
      int         n;
      bit         pb, we;
      logic [7:0] ad, wd;
      exp_t       e;
      n = cyc;
      if (!rst_n) begin
        eq.delete();
        sq.delete();
        next_idle = n + 1;
        busy_last = -1;
        last_b    = 1'b1;
        mrd[0]    = 8'h00;
        mrd[1]    = 8'h00;
        rst_seen  = 1'b1;
      end else begin
        rst_seen = 1'b0;
        if (n >= next_idle && (a_req || b_req)) begin
          pb     = (a_req && b_req) ? !last_b : b_req;
          last_b = pb;
          we     = pb ? b_we : a_we;
          ad     = pb ? b_addr : a_addr;
          wd     = pb ? b_wdata : a_wdata;
          e.b    = pb;
          e.err  = (ad > 8'h07);
          if (e.err) begin
            e.at      = n;
            next_idle = n + 2;
          end else begin
            e.at      = n + SC + 1;
            next_idle = n + SC + 3;
            sq.push_back('{we, ad, wd, n + 1});
            if (!we) mrd[pb] = dtab[(n + SC + 1) % 64];
          end
          e.rd      = mrd[pb];
          busy_last = e.at;
          eq.push_back(e);
        end
      end
    end

    logic [7:0] mon_rd [2];
    bit         s_on = 1'b0;
    bit         s_bad;
    bit         drained = 1'b0;
    str_t       s_obs;

    always @(negedge clk) begin : monitor
      int         l;
      bit         on;
      logic [3:0] exp_pat;
      exp_t       e;
      str_t       x;
      l = cyc - 1;
      if (rst_seen) begin
        check($sformatf("i%0d_reset_outputs", g),
              {busy, io_addr, io_Din, io_RE, io_WE, a_ack, b_ack, a_err, b_err, a_rdata, b_rdata}, 0);
        mon_rd[0] = 8'h00;
        mon_rd[1] = 8'h00;
        s_on      = 1'b0;
      end else begin
        check($sformatf("i%0d_busy", g), busy, l <= busy_last);
        exp_pat = 4'b0000;
        if (eq.size() > 0 && eq[0].at == l) begin
          e = eq.pop_front();
          exp_pat = e.b ? {1'b1, 1'b0, e.err, 1'b0} : {1'b0, 1'b1, 1'b0, e.err};
          mon_rd[e.b] = e.rd;
        end
        check($sformatf("i%0d_ack_err_b_a", g), {b_ack, a_ack, b_err, a_err}, exp_pat);
        check($sformatf("i%0d_a_rdata", g), a_rdata, mon_rd[0]);
        check($sformatf("i%0d_b_rdata", g), b_rdata, mon_rd[1]);
        check($sformatf("i%0d_re_we_exclusive", g), io_RE & io_WE, 0);

        on = io_RE | io_WE;
        if (sq.size() > 0 && sq[0].start == l) begin
          check($sformatf("i%0d_strobe_begin", g), on, 1);
          if (!on) void'(sq.pop_front());
        end
        if (on && !s_on) begin
          check($sformatf("i%0d_strobe_start_edge", g), l, (sq.size() > 0) ? sq[0].start : -1);
          s_on  = 1'b1;
          s_bad = 1'b0;
          s_obs = '{io_WE, io_addr, io_Din, l};
        end else if (on) begin
          if (s_obs.we != io_WE || s_obs.addr != io_addr || s_obs.din != io_Din) s_bad = 1'b1;
        end else if (s_on) begin
          s_on = 1'b0;
          if (sq.size() > 0) begin
            x = sq.pop_front();
            check($sformatf("i%0d_strobe_width", g), l - s_obs.start, SC);
            check($sformatf("i%0d_strobe_we_addr_din", g),
                  {s_obs.we, s_obs.addr, s_obs.din}, {x.we, x.addr, x.din});
            check($sformatf("i%0d_strobe_stable", g), s_bad, 0);
          end
        end
      end
      if (fin && !drained) begin
        drained = 1'b1;
        check($sformatf("i%0d_scoreboard_drained", g), eq.size() + sq.size(), 0);
      end
    end

    task automatic drive(input bit r, input bit we, input logic [7:0] ad, input logic [7:0] wd);
      if (r) begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
      else   begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
    endtask

    task automatic release_req(input bit r);
      if (r) b_req = 1'b0;
      else   a_req = 1'b0;
    endtask

    task automatic txn(input bit r, input bit we, input logic [7:0] ad, input logic [7:0] wd, input bit hold);
      int k;
      drive(r, we, ad, wd);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(r ? b_ack : a_ack) && k < 200);
      if (!hold) release_req(r);
    endtask

    task automatic rand_run(input bit r);
      bit         hold;
      logic [7:0] ad;
      hold = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        ad   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
        hold = (i != 15) && ($urandom_range(0, 1) == 1);
        txn(r, 1'($urandom_range(0, 1)), ad, 8'($urandom), hold);
      end
      release_req(1'b1 == r);
    endtask

    initial begin : script
      a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
      b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
      done1 = 1'b0;
      done2 = 1'b0;
      wait (start);
      @(negedge clk);
      txn(1'b0, 1'b0, 8'h03, 8'h00, 1'b0);
      txn(1'b1, 1'b1, 8'h07, 8'hC3, 1'b0);
      @(negedge clk);
      fork
        begin txn(1'b0, 1'b0, 8'h01, 8'h00, 1'b1); txn(1'b0, 1'b1, 8'h02, 8'h3C, 1'b0); end
        begin txn(1'b1, 1'b1, 8'h04, 8'h99, 1'b1); txn(1'b1, 1'b0, 8'h05, 8'h00, 1'b0); end
      join
      txn(1'b0, 1'b0, 8'h08, 8'h00, 1'b0);
      done1 = 1'b1;
      wait (go_rst);
      drive(1'b1, 1'b1, 8'h05, 8'hE7);
      for (int k = 0; k < 400 && rst_n; k++) @(negedge clk);
      release_req(1'b1);
      wait (go2);
      fork
        txn(1'b0, 1'b0, 8'h06, 8'h00, 1'b0);
        txn(1'b1, 1'b1, 8'h00, 8'h11, 1'b0);
      join
      txn(1'b0, 1'b0, 8'h03, 8'h00, 1'b0);
      fork
        rand_run(1'b0);
        rand_run(1'b1);
      join
      done2 = 1'b1;
    end
  end

  initial begin : main
    int k;
    foreach (dtab[i]) dtab[i] = 8'($urandom);
    rst_n  = 1'b0;
    start  = 1'b0;
    go_rst = 1'b0;
    go2    = 1'b0;
    fin    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;

    k = 0;
    while (!(inst[0].done1 && inst[1].done1 && inst[2].done1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("directed_phase_done", {inst[0].done1, inst[1].done1, inst[2].done1}, 3'b111);

    // Pull reset while the SC=2 instance is strobing a write.
    go_rst = 1'b1;
    k = 0;
    while (!inst[0].io_WE && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("write_strobe_before_reset", inst[0].io_WE, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go2 = 1'b1;

    k = 0;
    while (!(inst[0].done2 && inst[1].done2 && inst[2].done2) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("random_phase_done", {inst[0].done2, inst[1].done2, inst[2].done2}, 3'b111);
    repeat (30) @(negedge clk);
    fin = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_arbiter.md
# io_arbiter

Round-robin arbiter and bus sequencer for the 8-port I/O block. Two requesters share the single I/O access path: A is the CPU load/store path, B is the debug/DMA path. Each granted transaction runs as a fixed setup / strobe / done sequence that drives the I/O block's addr, RE, WE and Din, captures its Dout, and returns a one-cycle ack to the owner. Out-of-range addresses are rejected without strobing the port.

## Interface
- STROBE_CYCLES, 2, cycles RE/WE held high per access; legal range 1..15
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- a_req  in  1  requester A transaction request; held with fields stable until a_ack
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  8  A port address
- a_wdata  in  8  A write data
- a_ack  out  1  A completion pulse, one cycle
- a_err  out  1  A address error, valid with a_ack
- a_rdata  out  8  A read data, valid with a_ack on reads
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: same as A, for requester B
- io_addr  out  8  to I/O block addr
- io_RE  out  1  to I/O block RE
- io_WE  out  1  to I/O block WE
- io_Din  out  8  to I/O block Din
- io_Dout  in  8  from I/O block Dout
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SETUP, STROBE, DONE. A state counter cnt (4 bits) is used in STROBE.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both req high: grant the requester not in last_gnt. Update last_gnt on every grant.
- On grant, latch owner, we, addr and wdata.
  - addr > 8'h07: go to DONE with err=1. No strobes are issued.
  - Otherwise: go to SETUP.
- SETUP: io_addr and io_Din take the latched values; io_RE = io_WE = 0. Next state is STROBE with cnt = 0.
- STROBE:
  - io_RE = ~we, io_WE = we; io_addr and io_Din are held.
  - cnt increments each cycle.
  - When cnt == STROBE_CYCLES-1: on a read, capture io_Dout into the owner's rdata register; then go to DONE.
- DONE:
  - Strobes are 0.
  - The owner's ack = 1, and its err = 1 only for a rejected address.
  - Next state is IDLE.
- All outputs are registered.
- io_addr and io_Din hold their last values in IDLE and DONE.
- rdata registers hold their value until that requester's next successful read; they are unchanged on writes and on errors.
- After ack a requester may drop req, or keep it high to present a new transaction. A held req is re-arbitrated in IDLE and never bypasses IDLE.
- If req drops mid-transaction, the transaction still completes and ack still pulses.
- The non-owner's ack and err stay 0.

## Timing
- Reset (rst_n = 0 at an edge), all outputs after that edge:
  - state = IDLE, busy = 0, last_gnt = B (so A wins the first tie).
  - io_addr = 0, io_Din = 0, io_RE = 0, io_WE = 0.
  - a_ack = b_ack = 0, a_err = b_err = 0, a_rdata = b_rdata = 8'h00.
- Reset mid-transaction: strobes are 0 after that edge, no ack is issued, and the transaction is discarded.
- Latency for a valid address, with req first sampled in IDLE at edge 0:
  - SETUP occupies cycle 1.
  - STROBE occupies cycles 2..STROBE_CYCLES+1.
  - ack is high in cycle STROBE_CYCLES+2.
  - With the default of 2: ack in cycle 4, and 5 cycles per transaction including the return to IDLE.
- Latency for an invalid address: ack + err in cycle 1.
- Read data: io_Dout is sampled at the edge ending the last STROBE cycle, and rdata is valid in the ack cycle.
- Maximum back-to-back throughput: one transaction per STROBE_CYCLES+3 cycles.
- Both requesters saturated: grants alternate A, B, A, B…

## Test plan
- Reset, then A read at addr 8'h03 with io_Dout = 8'h5A:
  - io_RE high in cycles 2–3 with io_addr = 8'h03.
  - a_ack in cycle 4 with a_rdata = 8'h5A and a_err = 0.
  - No B activity.
- B write 8'hC3 to addr 8'h07:
  - io_WE high for exactly 2 cycles with io_Din = 8'hC3 and io_RE = 0 throughout.
  - b_ack pulses once; b_rdata unchanged.
- A and B both request from the same cycle, held continuously for 4 transactions:
  - Grant order is A, B, A, B.
  - Each ack comes 5 cycles after the previous one.
  - The non-owner's ack is never asserted.
- A request to addr 8'h08:
  - a_ack and a_err both high in cycle 1.
  - io_RE and io_WE never assert; a_rdata retains its old value.
- rst_n pulled low during STROBE of a write:
  - io_WE = 0 after that edge, no ack is issued, and all outputs are at their reset values.
  - A subsequent A request completes normally.
- STROBE_CYCLES = 1 and STROBE_CYCLES = 15: strobe width is exactly 1 and 15 cycles respectively, and ack arrives in cycle 3 and cycle 17.
